// File: rtl/keccak_msg_loader.sv
// keccak_msg_loader
//   Producer side of the Keccak hash input. Packs a valid/ready word stream
//   LSByte-first into an L-bit block, pulses o_start for one cycle, holds the
//   block until the core reports i_done, then clears and re-arms.
//
// Ports
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_v_word          input word (byte k at bits [8k+7:8k])
//   i_keep            byte enables, honoured on the last word only
//   i_valid, i_last   word valid, final word of message
//   o_ready           a word is accepted this cycle when i_valid is high
//   o_v_data          packed block to the hash core
//   o_start           one-cycle start pulse to the hash core
//   i_done            hash core done, looked at only while waiting
//   o_len             number of valid message bytes in o_v_data
//   o_busy            block launched, hash in progress
//
// state  | meaning
// FILL   | accepting words into the block buffer
// LAUNCH | block closed, start pulse to the core
// WAIT   | block held stable until i_done

module keccak_msg_loader #(
  parameter int L = 160,
  parameter int W = 32,
  localparam int N  = L / W,
  localparam int LW = $clog2(L / 8 + 1)
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic [W-1:0]   i_v_word,
  input  logic [W/8-1:0] i_keep,
  input  logic           i_valid,
  input  logic           i_last,
  output logic           o_ready,
  output logic [L-1:0]   o_v_data,
  output logic           o_start,
  input  logic           i_done,
  output logic [LW-1:0]  o_len,
  output logic           o_busy
);

  localparam int B  = W / 8;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] cnt;
  logic [L-1:0]  data_q;
  logic [LW-1:0] len_q;
  logic          accept;
  logic          close;
  logic          rearm;
  logic [W-1:0]  word_masked;
  logic [LW-1:0] word_bytes;

  function automatic logic [LW-1:0] popcount(input logic [B-1:0] k);
    logic [LW-1:0] p;
    p = '0;
    for (int i = 0; i < B; i++) begin
      p = p + LW'(k[i]);
    end
    return p;
  endfunction

  // Keep only matters on the last word; disabled bytes are stored as zero.
  always_comb begin
    word_masked = '0;
    for (int k = 0; k < B; k++) begin
      word_masked[8*k +: 8] = (i_last && !i_keep[k]) ? 8'h00 : i_v_word[8*k +: 8];
    end
    word_bytes = i_last ? popcount(i_keep) : LW'(B);
  end

  // Ready is gated by reset so nothing is taken while reset is asserted.
  assign accept = i_valid && (state == FILL) && !i_rst;
  // Filling the last slot closes the block even without i_last.
  assign close  = accept && (i_last || (cnt == CW'(N - 1)));
  assign rearm  = (state == WAIT) && i_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FILL;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    o_ready  = 1'b0;
    o_start  = 1'b0;
    o_busy   = 1'b0;
    case (state)
      FILL: begin
        o_ready = !i_rst;
        if (close) state_nx = LAUNCH;
      end
      LAUNCH: begin
        o_start  = !i_rst;
        o_busy   = !i_rst;
        state_nx = WAIT;
      end
      WAIT: begin
        o_busy = !i_rst;
        if (i_done) state_nx = FILL;
      end
      default: state_nx = FILL;
    endcase
  end

  // Clearing on re-arm provides the zero fill for words a short message never writes.
  always_ff @(posedge i_clk) begin
    if (i_rst || rearm) begin
      data_q <= '0;
      len_q  <= '0;
      cnt    <= '0;
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (cnt == CW'(i)) data_q[i*W +: W] <= word_masked;
      end
      len_q <= len_q + word_bytes;
      if (cnt != CW'(N - 1)) cnt <= cnt + CW'(1);
    end
  end

  assign o_v_data = data_q;
  assign o_len    = len_q;

endmodule

// File: tb/tb_keccak_msg_loader.sv
// tb_keccak_msg_loader
//   Randomized and directed stimulus for keccak_msg_loader (L=160, W=32),
//   checked against a byte-queue reference model of the packed block.

module tb_keccak_msg_loader;

  localparam int L  = 160;
  localparam int W  = 32;
  localparam int LW = 5;

  logic          i_clk;
  logic          i_rst;
  logic [W-1:0]  i_v_word;
  logic [3:0]    i_keep;
  logic          i_valid;
  logic          i_last;
  logic          o_ready;
  logic [L-1:0]  o_v_data;
  logic          o_start;
  logic          i_done;
  logic [LW-1:0] o_len;
  logic          o_busy;

  keccak_msg_loader #(.L(L), .W(W)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_v_word(i_v_word),
    .i_keep  (i_keep),
    .i_valid (i_valid),
    .i_last  (i_last),
    .o_ready (o_ready),
    .o_v_data(o_v_data),
    .o_start (o_start),
    .i_done  (i_done),
    .o_len   (o_len),
    .o_busy  (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int           n_chk = 0;
  int           n_pass = 0;
  logic [31:0]  msg_w [5];
  logic [159:0] exp_d;
  int           exp_l;

  task automatic chk(input string tag, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Block as a byte stream: every written word contributes four bytes,
  // with bytes beyond kc on a flagged last word forced to zero.
  function automatic logic [159:0] model_data(input int n, input bit lastf, input int kc);
    logic [7:0]   q[$];
    logic [159:0] d;
    d = '0;
    for (int j = 0; j < n; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (lastf && (j == n - 1) && (k >= kc)) q.push_back(8'h00);
        else q.push_back(msg_w[j][8*k +: 8]);
      end
    end
    foreach (q[i]) d[8*i +: 8] = q[i];
    return d;
  endfunction

  function automatic int model_len(input int n, input bit lastf, input int kc);
    return lastf ? (4 * (n - 1) + kc) : (4 * n);
  endfunction

  // Presents word j after a random gap and returns in the cycle after its accept.
  task automatic send_word(input int j, input bit lst, input logic [3:0] keep);
    int guard;
    repeat ($urandom_range(0, 2)) begin
      i_valid = 1'b0;
      i_done  = 1'($urandom);
      @(negedge i_clk);
    end
    i_valid  = 1'b1;
    i_v_word = msg_w[j];
    i_last   = lst;
    i_keep   = keep;
    i_done   = 1'($urandom);
    guard = 0;
    while (!o_ready && guard < 50) begin
      @(negedge i_clk);
      guard++;
    end
    if (guard >= 50) chk("ready_timeout", 160'd0, 160'd1);
    @(negedge i_clk);
    i_valid  = 1'b0;
    i_last   = 1'b0;
    i_done   = 1'b0;
    i_v_word = $urandom;
    i_keep   = 4'($urandom);
  endtask

  // Sends words j0..n-1 and checks the launch cycle.
  task automatic fill_msg(input int j0, input int n, input bit lastf, input int kc);
    logic [3:0] km;
    bit         lst;
    km = 4'((1 << kc) - 1);
    exp_d = model_data(n, lastf, kc);
    exp_l = model_len(n, lastf, kc);
    for (int j = j0; j < n; j++) begin
      lst = lastf && (j == n - 1);
      send_word(j, lst, lst ? km : 4'($urandom));
      if (j < n - 1) begin
        chk("fill_len", 160'(o_len), 160'(4 * (j + 1)));
        chk("fill_start", 160'(o_start), 160'd0);
        chk("fill_ready", 160'(o_ready), 160'd1);
      end
    end
    chk("launch_start", 160'(o_start), 160'd1);
    chk("launch_busy", 160'(o_busy), 160'd1);
    chk("launch_ready", 160'(o_ready), 160'd0);
    chk("launch_data", o_v_data, exp_d);
    chk("launch_len", 160'(o_len), 160'(exp_l));
  endtask

  // Called in the launch cycle: holds for a while, then completes the hash.
  task automatic finish_msg(input int hold, input bit early);
    if (early) i_done = 1'b1;
    @(negedge i_clk);
    i_done = 1'b0;
    chk("wait_start", 160'(o_start), 160'd0);
    chk("wait_busy", 160'(o_busy), 160'd1);
    chk("wait_ready", 160'(o_ready), 160'd0);
    repeat (hold) begin
      @(negedge i_clk);
      chk("hold_data", o_v_data, exp_d);
      chk("hold_len", 160'(o_len), 160'(exp_l));
      chk("hold_ready", 160'(o_ready), 160'd0);
    end
    i_done = 1'b1;
    @(negedge i_clk);
    i_done = 1'b0;
    chk("rearm_data", o_v_data, 160'd0);
    chk("rearm_len", 160'(o_len), 160'd0);
    chk("rearm_busy", 160'(o_busy), 160'd0);
    chk("rearm_ready", 160'(o_ready), 160'd1);
  endtask

  initial begin
    logic [159:0] d;
    logic [31:0]  held6;
    int           n;
    bit           lastf;

    i_rst = 1'b1; i_valid = 1'b0; i_last = 1'b0; i_keep = '0;
    i_v_word = '0; i_done = 1'b0;
    repeat (3) @(negedge i_clk);
    chk("rst_ready", 160'(o_ready), 160'd0);
    chk("rst_busy", 160'(o_busy), 160'd0);
    chk("rst_start", 160'(o_start), 160'd0);
    chk("rst_data", o_v_data, 160'd0);
    chk("rst_len", 160'(o_len), 160'd0);
    i_rst = 1'b0;
    #1;
    chk("post_rst_ready", 160'(o_ready), 160'd1);

    // full block of ascending bytes, early done ignored, long hold
    for (int j = 0; j < 5; j++)
      msg_w[j] = {8'(4*j+3), 8'(4*j+2), 8'(4*j+1), 8'(4*j)};
    fill_msg(0, 5, 1'b1, 4);
    d = '0;
    for (int i = 0; i < 20; i++) d[8*i +: 8] = 8'(i);
    chk("full_data", o_v_data, d);
    chk("full_len", 160'(o_len), 160'd20);
    finish_msg(40, 1'b1);

    // short message, partial keep
    msg_w[0] = 32'hAABBCCDD;
    msg_w[1] = 32'h11223344;
    fill_msg(0, 2, 1'b1, 2);
    chk("short_data", o_v_data, 160'h00003344_AABBCCDD);
    chk("short_len", 160'(o_len), 160'd6);
    finish_msg(3, 1'b0);

    // no last: implicit launch, sixth word held until re-arm
    for (int j = 0; j < 5; j++) msg_w[j] = $urandom;
    fill_msg(0, 5, 1'b0, 0);
    held6 = $urandom;
    i_valid = 1'b1; i_v_word = held6; i_last = 1'b0; i_keep = 4'($urandom);
    finish_msg(5, 1'b0);
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("held_len", 160'(o_len), 160'd4);
    chk("held_data", o_v_data, {128'd0, held6});
    msg_w[0] = held6;
    msg_w[1] = $urandom;
    fill_msg(1, 2, 1'b1, 4);
    finish_msg(1, 1'b0);

    // reset mid-message
    for (int j = 0; j < 3; j++) begin
      msg_w[j] = $urandom;
      send_word(j, 1'b0, 4'hF);
    end
    i_rst = 1'b1; i_valid = 1'b1; i_v_word = $urandom;
    #1;
    chk("rstm_ready_in_rst", 160'(o_ready), 160'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_valid = 1'b0;
    #1;
    chk("rstm_data", o_v_data, 160'd0);
    chk("rstm_len", 160'(o_len), 160'd0);
    chk("rstm_ready", 160'(o_ready), 160'd1);
    for (int j = 0; j < 5; j++) msg_w[j] = $urandom;
    fill_msg(0, 5, 1'b1, 4);
    finish_msg(2, 1'b0);

    // reset while waiting, with a pending done
    for (int j = 0; j < 3; j++) msg_w[j] = $urandom;
    fill_msg(0, 3, 1'b1, 3);
    @(negedge i_clk);
    i_rst = 1'b1; i_done = 1'b1;
    #1;
    chk("rstw_busy_in_rst", 160'(o_busy), 160'd0);
    @(negedge i_clk);
    i_rst = 1'b0; i_done = 1'b0;
    #1;
    chk("rstw_busy", 160'(o_busy), 160'd0);
    chk("rstw_ready", 160'(o_ready), 160'd1);
    chk("rstw_data", o_v_data, 160'd0);
    chk("rstw_len", 160'(o_len), 160'd0);
    chk("rstw_start", 160'(o_start), 160'd0);

    // empty last word
    msg_w[0] = $urandom;
    fill_msg(0, 1, 1'b1, 0);
    chk("empty_data", o_v_data, 160'd0);
    chk("empty_len", 160'(o_len), 160'd0);
    finish_msg(0, 1'b1);

    // random messages
    repeat (150) begin
      n = $urandom_range(1, 5);
      lastf = (n < 5) ? 1'b1 : 1'($urandom);
      for (int j = 0; j < 5; j++) msg_w[j] = $urandom;
      fill_msg(0, n, lastf, $urandom_range(0, 4));
      finish_msg($urandom_range(0, 5), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keccak_msg_loader.md
Name: keccak_msg_loader

Overview:
- Producer side of the Keccak hash input interface.
- Accepts a message as a stream of W-bit words with valid/ready/last/keep and packs them LSByte-first into the L-bit block the hash core absorbs.
- Pulses the hash start for exactly one cycle, holds the block stable until the core reports done, then re-arms for the next message.
- Sits between the nonce/blob assembly logic and the Keccak hash core in the miner front end.

Parameters:
- L, 160, block width in bits presented to the hash core; multiple of W.
- W, 32, input word width in bits; multiple of 8.
- N (localparam), L/W, words per block.
- LW (localparam), clog2(L/8+1), width of the byte-length output.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_v_word  in  W  input word; byte k occupies bits [8k+7:8k].
- i_keep  in  W/8  byte enables; honoured only on the last word, must be contiguous from bit 0.
- i_valid  in  1  word valid.
- i_last  in  1  final word of the message.
- o_ready  out  1  loader accepts a word this cycle.
- o_v_data  out  L  packed block to the hash core (i_v_data of core), LSByte-first.
- o_start  out  1  one-cycle start pulse to the hash core.
- i_done  in  1  done from the hash core.
- o_len  out  LW  number of valid message bytes in o_v_data.
- o_busy  out  1  block launched, hash in progress.

Behaviour:
- Reset (i_rst=1 at an edge, any state, including mid-message or mid-hash):
  - o_v_data=0, o_len=0, o_start=0, o_busy=0, o_ready=0 for that cycle.
  - Word counter cleared; state FILL from the next cycle.
  - A pending i_done is ignored. Any in-flight hash is the owner's to reset.
- States:
  - FILL: o_ready=1, o_busy=0.
  - LAUNCH: o_ready=0, o_start=1, o_busy=1.
  - WAIT: o_ready=0, o_start=0, o_busy=1.
- FILL accept: a word is accepted when i_valid&&o_ready.
  - Word index cnt (0..N-1) is written to o_v_data[cnt*W +: W]; cnt increments.
  - First word lands in the lowest bits.
- Non-last words: i_keep is ignored; all W/8 bytes are valid; o_len += W/8.
- Last word (i_last=1):
  - Bytes with i_keep[k]=0 are written as 0x00.
  - o_len += popcount(i_keep).
  - i_keep=0 on a last word is legal: it adds no bytes and closes the message.
- FILL -> LAUNCH: on the accept of a word with i_last=1, or of word index N-1 regardless of i_last (block full; an implicit last).
- Unwritten words: words never written stay 0 (zero fill), because the buffer is cleared on re-arm.
- Launch latency: a word accepted at edge t closes the block, and o_start=1 during cycle t+1 only.
- LAUNCH -> WAIT: unconditional after one cycle.
- i_done: sampled only in WAIT; i_done in FILL or LAUNCH is ignored.
- WAIT -> FILL: on i_done=1. On the same edge, o_v_data and o_len clear to 0 and cnt clears to 0; o_ready=1 the following cycle.
- Data hold: o_v_data and o_len stay constant from the edge closing the block until the edge that sees i_done.
- Back-pressure: while o_ready=0, upstream holds its word; no word is dropped or duplicated.
- Width rules:
  - o_len saturates by construction at L/8.
  - cnt is clog2(N) bits, or 1 bit when N=1; it never wraps, because reaching N-1 forces launch.

Test Plan (L=160, W=32):
- Full block: 5 words 0x03020100, 0x07060504, ... 0x13121110 with i_last on the 5th, no stalls.
  - o_v_data = bytes 0x00..0x13 ascending from LSB; o_len=20.
  - o_start high exactly one cycle, the cycle after the 5th accept.
- Short message with partial keep: 2 words 0xAABBCCDD, 0x11223344; last with i_keep=4'b0011.
  - o_v_data[63:0]=0x00003344_AABBCCDD, upper 96 bits 0; o_len=6.
- No last asserted: 5 words without i_last.
  - Launch after the 5th word; o_ready=0 until i_done.
  - A 6th word held valid is accepted only in the cycle after i_done and becomes word 0 of a zeroed block.
- Hold and done timing:
  - Assert i_done during the LAUNCH cycle -> ignored, state stays WAIT.
  - Assert i_done 40 cycles later -> o_v_data unchanged throughout, then 0; o_busy falls and o_ready rises next cycle.
- Reset mid-message and mid-hash:
  - Reset after 3 words -> o_v_data=0, o_len=0; the next 5 words form a clean block.
  - Reset in WAIT -> o_busy=0, FILL resumes.
- Empty last: a single word with i_last=1, i_keep=0 -> o_len=0, o_v_data=0, o_start still pulses once.
